// File: rtl/conv_window_3x3_gen_if.sv
// Pixel stream in / 3x3 window out bundle for conv_window_3x3_gen.
// win_last exists only when CONV_WIN_LAST_EN is defined.
interface conv_window_3x3_gen_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] data00, data01, data02;
  logic signed [DATA_W-1:0] data10, data11, data12;
  logic signed [DATA_W-1:0] data20, data21, data22;
  logic                     win_valid;
`ifdef CONV_WIN_LAST_EN
  logic                     win_last;
`endif

  modport master (
    output in_valid, in_sof, in_data,
    input  data00, data01, data02,
    input  data10, data11, data12,
    input  data20, data21, data22,
    input  win_valid
`ifdef CONV_WIN_LAST_EN
    , input win_last
`endif
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output data00, data01, data02,
    output data10, data11, data12,
    output data20, data21, data22,
    output win_valid
`ifdef CONV_WIN_LAST_EN
    , output win_last
`endif
  );
endinterface

// File: rtl/conv_window_3x3_gen.sv
// 3x3 valid-window generator over a raster pixel stream, two line buffers.
// Optional win_last output enabled by CONV_WIN_LAST_EN.
module conv_window_3x3_gen #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_W     = 16
) (
  input logic               sclk,
  input logic               s_rst,
  conv_window_3x3_gen_if.slave win
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;

  logic signed [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic signed [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic signed [DATA_W-1:0] lb_mid, lb_top;

  logic signed [DATA_W-1:0] d00, d01, d02;
  logic signed [DATA_W-1:0] d10, d11, d12;
  logic signed [DATA_W-1:0] d20, d21, d22;
  logic                     vld;
`ifdef CONV_WIN_LAST_EN
  logic                     lst;
`endif

  // in_sof forces the current beat to (0,0)
  assign c = win.in_sof ? '0 : col;
  assign r = win.in_sof ? '0 : row;

  assign lb_mid = lb1[c];
  assign lb_top = lb2[c];

  // line buffers: push the column down one row, read-before-write
  always_ff @(posedge sclk) begin
    if (win.in_valid) begin
      lb2[c] <= lb_mid;
      lb1[c] <= win.in_data;
    end
  end

  // window shift, strobe and raster position tracking
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      col <= '0;
      row <= '0;
      d00 <= '0; d01 <= '0; d02 <= '0;
      d10 <= '0; d11 <= '0; d12 <= '0;
      d20 <= '0; d21 <= '0; d22 <= '0;
      vld <= 1'b0;
`ifdef CONV_WIN_LAST_EN
      lst <= 1'b0;
`endif
    end else if (win.in_valid) begin
      d00 <= d01; d01 <= d02; d02 <= lb_top;
      d10 <= d11; d11 <= d12; d12 <= lb_mid;
      d20 <= d21; d21 <= d22; d22 <= win.in_data;
      vld <= (r >= R_TWO) && (c >= C_TWO);
`ifdef CONV_WIN_LAST_EN
      lst <= (r == R_LAST) && (c == C_LAST);
`endif
      if (c == C_LAST) begin
        col <= '0;
        row <= (r == R_LAST) ? '0 : r + 1'b1;
      end else begin
        col <= c + 1'b1;
        row <= r;
      end
    end else begin
      vld <= 1'b0;
`ifdef CONV_WIN_LAST_EN
      lst <= 1'b0;
`endif
    end
  end

  assign win.data00 = d00;
  assign win.data01 = d01;
  assign win.data02 = d02;
  assign win.data10 = d10;
  assign win.data11 = d11;
  assign win.data12 = d12;
  assign win.data20 = d20;
  assign win.data21 = d21;
  assign win.data22 = d22;
  assign win.win_valid = vld;
`ifdef CONV_WIN_LAST_EN
  assign win.win_last = lst;
`endif
endmodule

// File: tb/tb_conv_window_3x3_gen.sv
// Scoreboard bench for conv_window_3x3_gen on a 5x5 image.
// win_last is checked when CONV_WIN_LAST_EN is defined.
module tb_conv_window_3x3_gen;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 16;

  typedef logic [8:0][DW-1:0] taps_t;
  typedef struct packed {
    taps_t t;
    logic  last;
  } exp_t;

  logic sclk = 1'b0;
  logic s_rst;
  always #5 sclk = ~sclk;

  conv_window_3x3_gen_if #(.DATA_W(DW)) win();

  conv_window_3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .sclk (sclk),
    .s_rst(s_rst),
    .win  (win)
  );

  int    total = 0;
  int    bad = 0;
  int    strobes = 0;
  int    acc_cnt = 0;
  int    first_acc = 0;
  int    gcyc = 0;
  int    img [W*H];
  bit    first_seen = 0;
  taps_t first_taps, last_taps;
  logic  acc_prev = 1'b0;
  exp_t  exp_q [$];
  int    last_at [$];

  task automatic chk_int(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_taps(input string nm, input taps_t act, input taps_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic taps_t pack9(input int v [9]);
    taps_t t;
    for (int k = 0; k < 9; k++) t[k] = DW'(v[k]);
    return t;
  endfunction

  function automatic taps_t taps_now();
    taps_t t;
    t[0] = win.data00; t[1] = win.data01; t[2] = win.data02;
    t[3] = win.data10; t[4] = win.data11; t[5] = win.data12;
    t[6] = win.data20; t[7] = win.data21; t[8] = win.data22;
    return t;
  endfunction

  // acceptance history for latency and idle-gap checks
  always @(posedge sclk) begin
    acc_prev <= win.in_valid;
    if (win.in_valid && !s_rst) acc_cnt <= acc_cnt + 1;
  end

  // monitor: pop expected window on every strobe
  always @(negedge sclk) begin
    exp_t  e;
    taps_t got;
    got = taps_now();
    if (win.win_valid === 1'b1) begin
      strobes++;
      chk_int("valid_after_idle", int'(acc_prev), 1);
      if (!first_seen) begin
        first_seen = 1;
        first_taps = got;
        first_acc  = acc_cnt;
      end
      last_taps = got;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        chk_taps("taps", got, e.t);
`ifdef CONV_WIN_LAST_EN
        chk_int("win_last", int'(win.win_last), int'(e.last));
        if (win.win_last) last_at.push_back(strobes);
`endif
      end
    end
`ifdef CONV_WIN_LAST_EN
    else if (win.win_last !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL win_last_idle actual=%b required=0", win.win_last);
    end
`endif
  end

  task automatic send(input bit sof, input bit gaps, input int n);
    exp_t e;
    int   r, c;
    for (int i = 0; i < n; i++) begin
      if (gaps && (gcyc % 3 == 2)) begin
        @(negedge sclk);
        win.in_valid = 1'b0;
        win.in_sof   = 1'b0;
        gcyc++;
      end
      @(negedge sclk);
      gcyc++;
      win.in_valid = 1'b1;
      win.in_sof   = sof && (i == 0);
      win.in_data  = DW'(img[i]);
      r = i / W;
      c = i % W;
      if (r >= 2 && c >= 2) begin
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            e.t[3*y+x] = DW'(img[(r-2+y)*W + c-2+x]);
        e.last = (r == H-1) && (c == W-1);
        exp_q.push_back(e);
      end
    end
    @(negedge sclk);
    win.in_valid = 1'b0;
    win.in_sof   = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge sclk);
    chk_int("queue_empty", exp_q.size(), 0);
  endtask

  task automatic start_test();
    strobes    = 0;
    first_seen = 0;
    gcyc       = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    s_rst        = 1'b1;
    win.in_valid = 1'b0;
    win.in_sof   = 1'b0;
    win.in_data  = '0;
    repeat (2) @(negedge sclk);
    chk_taps("reset_taps", taps_now(), '0);
    chk_int("reset_valid", int'(win.win_valid), 0);
    s_rst = 1'b0;

    // basic ramp frame
    for (int i = 0; i < W*H; i++) img[i] = i;
    start_test();
    base = acc_cnt;
    send(1, 0, W*H);
    drain();
    chk_int("basic_strobes", strobes, 9);
    chk_int("basic_latency", first_acc - base, 13);
    chk_taps("basic_first", first_taps,
             pack9('{0, 1, 2, 5, 6, 7, 10, 11, 12}));
    chk_taps("basic_last", last_taps,
             pack9('{12, 13, 14, 17, 18, 19, 22, 23, 24}));

    // same frame with every third cycle idle
    start_test();
    send(1, 1, W*H);
    drain();
    chk_int("gaps_strobes", strobes, 9);
    chk_taps("gaps_first", first_taps,
             pack9('{0, 1, 2, 5, 6, 7, 10, 11, 12}));
    chk_taps("gaps_last", last_taps,
             pack9('{12, 13, 14, 17, 18, 19, 22, 23, 24}));

    // signed extremes
    for (int i = 0; i < W*H; i++)
      img[i] = (i % 3 == 0) ? -32768 : (i % 3 == 1) ? -1 : 32767;
    start_test();
    send(1, 0, W*H);
    drain();
    chk_int("signed_strobes", strobes, 9);
    chk_taps("signed_first", first_taps,
             pack9('{-32768, -1, 32767, 32767, -32768, -1,
                     -1, 32767, -32768}));

    // frame B restarts after 8 pixels of frame A
    for (int i = 0; i < W*H; i++) img[i] = 50 + i;
    start_test();
    send(1, 0, 8);
    for (int i = 0; i < W*H; i++) img[i] = 100 + i;
    send(1, 0, W*H);
    drain();
    chk_int("sof_strobes", strobes, 9);
    chk_taps("sof_first", first_taps,
             pack9('{100, 101, 102, 105, 106, 107, 110, 111, 112}));

    // reset during row 3, next frame without in_sof
    for (int i = 0; i < W*H; i++) img[i] = 200 + i;
    start_test();
    send(1, 0, 17);
    @(negedge sclk);
    s_rst = 1'b1;
    @(negedge sclk);
    chk_taps("midrst_taps", taps_now(), '0);
    chk_int("midrst_valid", int'(win.win_valid), 0);
    @(negedge sclk);
    s_rst = 1'b0;
    chk_int("midrst_pre_strobes", strobes, 3);
    for (int i = 0; i < W*H; i++) img[i] = 300 + i;
    start_test();
    send(0, 0, W*H);
    drain();
    chk_int("midrst_strobes", strobes, 9);
    chk_taps("midrst_first", first_taps,
             pack9('{300, 301, 302, 305, 306, 307, 310, 311, 312}));

    // two frames in a row, in_sof only on the first
    for (int i = 0; i < W*H; i++) img[i] = 400 + i;
    start_test();
    last_at.delete();
    send(1, 0, W*H);
    for (int i = 0; i < W*H; i++) img[i] = 500 + i;
    send(0, 0, W*H);
    drain();
    chk_int("wrap_strobes", strobes, 18);
    chk_taps("wrap_last", last_taps,
             pack9('{512, 513, 514, 517, 518, 519, 522, 523, 524}));
`ifdef CONV_WIN_LAST_EN
    chk_int("last_count", last_at.size(), 2);
    if (last_at.size() == 2) begin
      chk_int("last_pos0", last_at[0], 9);
      chk_int("last_pos1", last_at[1], 18);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_window_3x3_gen.md
Name: conv_window_3x3_gen

Overview:
- Producer of the 3x3 convolution window for the kernel adder/multiplier stage.
- Accepts a raster-order pixel stream, one pixel per accepted beat.
- Keeps the two previous image rows in line buffers.
- Emits nine signed taps data00..data22 plus a one-cycle valid strobe for every fully-inside ("valid", no padding) 3x3 window.

Parameters:
- IMG_WIDTH, 28, pixels per row; legal range 3..1024.
- IMG_HEIGHT, 28, rows per frame; legal range 3..1024.
- DATA_W, 16, signed pixel/tap width.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- s_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel accepted on this edge when high; no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid; marks the pixel as (row 0, col 0).
- in_data  in  DATA_W  signed pixel.
- data00, data01, data02  out  DATA_W  top row of window (oldest row), left to right.
- data10, data11, data12  out  DATA_W  middle row of window.
- data20, data21, data22  out  DATA_W  bottom row of window (current row).
- win_valid  out  1  one-cycle strobe; taps form a valid window.

Behaviour:
- Reset (s_rst=1 at edge):
  - col=0, row=0, all nine taps=0, win_valid=0.
  - Line-buffer contents are not reset (don't-care; overwritten before use).
- in_valid=0: no state change; win_valid=0 next cycle; taps hold.
- Accepted pixel at position (r,c), where (r,c)=(0,0) if in_sof else current counters:
  - Tap shift: dX0<=dX1, dX1<=dX2 for X=0,1,2.
  - New right column: data02<=lb2[c], data12<=lb1[c], data22<=in_data.
  - Line-buffer update, same edge: lb2[c]<=lb1[c], lb1[c]<=in_data (read-before-write).
  - win_valid<=1 iff r>=2 and c>=2; else 0.
  - Counters: c==IMG_WIDTH-1 -> col=0, row++; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0. Next frame may start without in_sof.
- Latency: taps and win_valid registered one cycle after the pixel completing the window. No other output pipelining.
- Throughput:
  - One window per cycle under back-to-back in_valid.
  - (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
- Taps at c=0,1 of each row hold mixed previous-row data and are undefined for consumers; win_valid=0 there.
- in_sof mid-frame: counters resync immediately. Stale line-buffer data is never emitted as valid because r>=2 requires two fresh rows.
- Reset mid-frame: next accepted pixel is treated as (0,0), regardless of in_sof.
- Line buffers: two IMG_WIDTH x DATA_W arrays, single write port each. Inferable as distributed or block RAM with a 1-cycle-read-compatible structure.
- Arithmetic: none. Signed values pass through unaltered; sign is preserved.

Optional Feature:
- Macro: CONV_WIN_LAST_EN.
- Defined:
  - Adds output port win_last (1 bit), reset 0.
  - win_last=1 together with win_valid for the window whose bottom-right pixel is (IMG_HEIGHT-1, IMG_WIDTH-1); 0 otherwise.
- Undefined: port absent; no other behaviour change.

Test Plan:
- Basic 5x5 (IMG_WIDTH=IMG_HEIGHT=5), pixel=r*5+c, back-to-back, in_sof on first beat:
  - First win_valid one cycle after pixel 12, with taps 0,1,2 / 5,6,7 / 10,11,12.
  - Exactly 9 strobes.
  - Last window taps 12,13,14 / 17,18,19 / 22,23,24.
- Gaps: same 5x5 frame with in_valid low on every third cycle:
  - Identical tap sequence and 9 strobes.
  - win_valid never high in a cycle following in_valid=0.
- Signed data: pixels -32768, -1, 32767 repeating in a 5x5 frame:
  - Taps reproduce exact bit patterns; no sign corruption.
- Mid-frame in_sof: after 8 pixels of frame A, assert in_sof with new 5x5 frame B (value 100+index):
  - First strobe taps 100,101,102 / 105,106,107 / 110,111,112.
  - Exactly 9 strobes for frame B.
- Reset mid-frame: s_rst high for 2 cycles during row 3:
  - Outputs 0 next cycle.
  - Following frame (no in_sof) produces 9 correct windows.
- Frame wrap with CONV_WIN_LAST_EN defined: two consecutive 5x5 frames, in_sof only on first:
  - 18 strobes.
  - win_last high exactly on strobe 9 and 18.
